reaction_core: RTL and testbench
================================

Name: reaction_core

Overview:
- Game engine for the reaction-time tester. It drives the status/score inputs of the text layout stage: status code, BCD time, lit/miss colour flags and the init flag.
- Sequences IDLE -> READY (random hold-off) -> LIT (timing) -> HIT/MISS.
- Measures the reaction in BCD as mmm.uuu (ms.us) and keeps the last and best results.
- Sits between the synchronized/debounced button and the layout/renderer, in the pixel clock domain.

Parameters:
CLK_HZ, 25_000_000, clock frequency; microsecond prescale US_DIV = CLK_HZ/1_000_000 (must be an integer >= 1)
MIN_DELAY_MS, 1000, minimum READY hold-off in ms
RAND_BITS, 10, LFSR bits added to the hold-off: delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0] ms
LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit LFSR

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  reset; asynchronous, active-high
i_btn  in  1  button level, already synchronized and debounced
i_bcdmux  in  1  0 = present last result, 1 = present best result (driven by layout per text row)
o_dst  out  3  status code: 000 idle, 001 ready, 010 lit, 011 miss, 110 hit
o_bcd  out  24  six BCD digits, [23:12] ms, [11:0] us
o_lit  out  1  high in LIT
o_miss  out  1  high in MISS
o_init  out  1  high until the first successful hit

Behaviour:
- Reset (async, active-high): state IDLE, o_dst=000, o_lit=0, o_miss=0, o_init=1, last=best=timer=0, prescalers 0, delay 0, LFSR=LFSR_SEED, btn_q=0.
- press = i_btn & ~btn_q; btn_q is registered each cycle. State and outputs change on the clock edge where press=1, so o_dst follows an i_btn rise after 1 cycle.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, free-running every cycle in all states.
- us_tick: one-cycle pulse every US_DIV cycles. ms_tick: every 1000 us_ticks. Both prescalers clear on every state transition, so the first tick comes exactly US_DIV cycles after entry.
- IDLE: press -> READY; load delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0] (binary, 16 bit).
- READY: ms_tick decrements delay. Press -> MISS. Delay reaching 0 on an ms_tick -> LIT and timer cleared. Press wins over simultaneous expiry (MISS).
- LIT: each us_tick increments timer as a 6-digit BCD counter with carries across all digits.
  - Press -> HIT. last <= timer, where timer is the registered value; a tick in the same cycle is dropped.
  - If o_init or timer < best: best <= timer. o_init <= 0.
  - us_tick while timer == 999_999 -> MISS (timeout); timer does not wrap.
  - Press in the same cycle as the timeout tick -> HIT with 999.999.
- Packed-BCD unsigned compare equals numeric compare; the compare is a plain 24-bit unsigned compare.
- MISS / HIT: hold until press, then -> READY with a new delay load, as from IDLE. No path back to IDLE except reset.
- MISS never modifies last, best or o_init.
- o_bcd = i_bcdmux ? best : last. Combinational, zero latency, since the layout toggles i_bcdmux per text row. All other outputs are registered/decoded from the state register.
- o_lit = (state==LIT); o_miss = (state==MISS); o_dst is the state encoding itself.
- Reset mid-operation (any state): immediate IDLE, all values per the reset list.

Decomposition:
- Package reaction_pkg:
  - state enum (3 bit, values equal to the o_dst codes): IDLE 3'b000, READY 3'b001, LIT 3'b010, MISS 3'b011, HIT 3'b110
  - BCD_MAX = 24'h999999
  - LFSR tap mask
- Sub-module bcd_timer holds the 6-digit counter:
  - inputs: clear, tick
  - outputs: value[23:0], at_max
- The FSM, prescalers, LFSR and last/best registers stay in reaction_core.

Test Plan:
Bench uses CLK_HZ=1_000_000 (US_DIV=1), MIN_DELAY_MS=2, RAND_BITS=2.
1. Release reset -> o_dst=000, o_init=1, o_lit=0, o_miss=0, o_bcd=24'h000000 for both i_bcdmux values; LFSR holds 16'hACE1.
2. Press in IDLE -> o_dst=001 next cycle; press again within 100 cycles -> o_dst=011, o_miss=1, o_init still 1, last=best=0.
3. Press from MISS, wait for o_lit=1, press after exactly 1234 lit cycles -> o_dst=110, o_bcd=24'h001234 with i_bcdmux=0 and with i_bcdmux=1, o_init=0.
4. Further rounds of 2000 then 500 lit cycles:
   - after the 2000 round: last=24'h002000, best=24'h001234
   - after the 500 round: last=24'h000500, best=24'h000500
5. Timeout: no press for 1_000_000 lit cycles -> o_dst=011, last/best unchanged. Separately, press on the cycle the delay reaches 0 in READY -> MISS, not LIT.
6. Assert i_rst asynchronously mid-LIT, between clock edges -> outputs reach reset values before the next edge; best/last=0, o_init=1.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game engine.
package reaction_pkg;

  // The state codes are driven straight out as the layout status code.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_READY = 3'b001,
    ST_LIT   = 3'b010,
    ST_MISS  = 3'b011,
    ST_HIT   = 3'b110
  } state_e;

  localparam logic [23:0] BCD_MAX   = 24'h999999;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_core_bcd_timer.sv
// Six-digit packed-BCD up counter with synchronous clear; saturates at 999999.
module bcd_timer
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        tick,
  output logic [23:0] value,
  output logic        at_max
);

  logic [23:0] cnt_q, cnt_d;
  logic        carry;

  assign value  = cnt_q;
  assign at_max = (cnt_q == BCD_MAX);

  // Ripple the increment upward; a digit at 9 wraps and passes the carry on.
  always_comb begin
    cnt_d = cnt_q;
    carry = tick & ~at_max;
    if (clear) begin
      cnt_d = '0;
      carry = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (cnt_q[i*4 +: 4] == 4'd9) begin
          cnt_d[i*4 +: 4] = 4'd0;
        end else begin
          cnt_d[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reaction_core.sv
// Reaction-time game engine: random hold-off, BCD reaction timer, last/best results.
module reaction_core
  import reaction_pkg::*;
#(
  parameter int          CLK_HZ       = 25_000_000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 10,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn,
  input  logic        i_bcdmux,
  output logic [2:0]  o_dst,
  output logic [23:0] o_bcd,
  output logic        o_lit,
  output logic        o_miss,
  output logic        o_init
);

  localparam int US_DIV = CLK_HZ / 1_000_000;
  localparam int USW    = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  state_e         state_q, state_d;
  logic           btn_q;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [USW-1:0] us_cnt_q, us_cnt_d;
  logic [9:0]     ms_cnt_q, ms_cnt_d;
  logic [15:0]    delay_q, delay_d;
  logic [23:0]    last_q, last_d, best_q, best_d;
  logic           init_q, init_d;
  logic [23:0]    timer;
  logic           timer_max, timer_clear, timer_tick;
  logic           press, us_tick, ms_tick, trans;

  assign press   = i_btn & ~btn_q;
  assign us_tick = (us_cnt_q == USW'(US_DIV - 1));
  assign ms_tick = us_tick && (ms_cnt_q == 10'd999);
  assign trans   = (state_d != state_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A press always wins over a simultaneous expiry or timeout tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_MISS, ST_HIT: if (press) state_d = ST_READY;
      ST_READY: begin
        if (press)                             state_d = ST_MISS;
        else if (ms_tick && delay_q <= 16'd1)  state_d = ST_LIT;
      end
      ST_LIT: begin
        if (press)                       state_d = ST_HIT;
        else if (us_tick && timer_max)   state_d = ST_MISS;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_dst  = state_q;
    o_lit  = (state_q == ST_LIT);
    o_miss = (state_q == ST_MISS);
    o_init = init_q;
    o_bcd  = i_bcdmux ? best_q : last_q;
  end

  assign timer_clear = (state_q == ST_READY) && (state_d == ST_LIT);
  assign timer_tick  = us_tick && (state_q == ST_LIT) && !press;

  bcd_timer u_timer (
    .clk    (i_clk),
    .rst    (i_rst),
    .clear  (timer_clear),
    .tick   (timer_tick),
    .value  (timer),
    .at_max (timer_max)
  );

  always_comb begin
    lfsr_d   = lfsr_step(lfsr_q);
    us_cnt_d = (trans || us_tick) ? '0 : us_cnt_q + 1'b1;
    ms_cnt_d = ms_cnt_q;
    if (trans)        ms_cnt_d = '0;
    else if (us_tick) ms_cnt_d = (ms_cnt_q == 10'd999) ? 10'd0 : ms_cnt_q + 10'd1;

    delay_d = delay_q;
    if (state_d == ST_READY && state_q != ST_READY)
      delay_d = 16'(MIN_DELAY_MS) + 16'(lfsr_q[RAND_BITS-1:0]);
    else if (state_q == ST_READY && ms_tick && delay_q != 16'd0)
      delay_d = delay_q - 16'd1;

    // Results latch the registered timer value; MISS leaves them alone.
    last_d = last_q;
    best_d = best_q;
    init_d = init_q;
    if (state_q == ST_LIT && press) begin
      last_d = timer;
      if (init_q || timer < best_q) best_d = timer;
      init_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_q    <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      us_cnt_q <= '0;
      ms_cnt_q <= '0;
      delay_q  <= '0;
      last_q   <= '0;
      best_q   <= '0;
      init_q   <= 1'b1;
    end else begin
      btn_q    <= i_btn;
      lfsr_q   <= lfsr_d;
      us_cnt_q <= us_cnt_d;
      ms_cnt_q <= ms_cnt_d;
      delay_q  <= delay_d;
      last_q   <= last_d;
      best_q   <= best_d;
      init_q   <= init_d;
    end
  end

endmodule

// File: tb/tb_reaction_core.sv
// Self-checking bench for reaction_core against a cycle-count / integer result model.
module tb_reaction_core;

  localparam int          CLK_HZ = 1_000_000;
  localparam int          MIN_MS = 2;
  localparam int          RBITS  = 2;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic        clk = 1'b0, rst = 1'b0, btn = 1'b0, bcdmux = 1'b0;
  logic [2:0]  dst;
  logic [23:0] bcd;
  logic        lit, miss, init;

  reaction_core #(
    .CLK_HZ(CLK_HZ), .MIN_DELAY_MS(MIN_MS), .RAND_BITS(RBITS), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_bcdmux(bcdmux),
    .o_dst(dst), .o_bcd(bcd), .o_lit(lit), .o_miss(miss), .o_init(init)
  );

  always #5 clk = ~clk;

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11 in right-shifting Galois form.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[15] = ~n[15]; n[13] = ~n[13]; n[12] = ~n[12]; n[10] = ~n[10];
    end
    return n;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= ref_lfsr(m_lfsr);
  end

  int total = 0, bad = 0;
  int m_last = 0, m_best = 0;
  bit m_init = 1'b1;
  int pend_d = 0;

  // Single-cycle button pulse launched at a negedge; records the hold-off it will load.
  task automatic press();
    btn = 1'b1;
    pend_d = MIN_MS + int'(m_lfsr[RBITS-1:0]);
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic wait_lit(output int cnt);
    cnt = 0;
    while (!lit && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 40)) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (dst !== 3'b000) begin bad++; $display("FAIL reset_dst got %b want 000", dst); end
    total++; if ({init, lit, miss} !== 3'b100) begin bad++; $display("FAIL reset_flags got %b want 100", {init, lit, miss}); end
    total++; if (bcd !== 24'h0) begin bad++; $display("FAIL reset_last got %h want 000000", bcd); end
    bcdmux = 1'b1; #1;
    total++; if (bcd !== 24'h0) begin bad++; $display("FAIL reset_best got %h want 000000", bcd); end
    bcdmux = 1'b0;
    total++; if (dut.lfsr_q !== SEED) begin bad++; $display("FAIL reset_lfsr got %h want %h", dut.lfsr_q, SEED); end
    @(negedge clk);
  endtask

  task automatic test_early_press();
    press();
    total++; if (dst !== 3'b001) begin bad++; $display("FAIL idle_to_ready got %b want 001", dst); end
    repeat ($urandom_range(1, 90)) @(negedge clk);
    press();
    total++; if (dst !== 3'b011 || miss !== 1'b1) begin bad++; $display("FAIL early_miss dst=%b miss=%b want 011/1", dst, miss); end
    total++; if (init !== 1'b1) begin bad++; $display("FAIL early_init got %b want 1", init); end
    bcdmux = 1'b0; #1;
    total++; if (bcd !== 24'h0) begin bad++; $display("FAIL early_last got %h want 000000", bcd); end
    bcdmux = 1'b1; #1;
    total++; if (bcd !== 24'h0) begin bad++; $display("FAIL early_best got %h want 000000", bcd); end
    bcdmux = 1'b0;
  endtask

  task automatic test_round(input int n, input string nm);
    int hold, d;
    idle_gap();
    press();
    d = pend_d;
    wait_lit(hold);
    total++; if (hold !== d * 1000) begin bad++; $display("FAIL %s_holdoff got %0d want %0d", nm, hold, d * 1000); end
    repeat (n) @(negedge clk);
    press();
    if (m_init || n < m_best) m_best = n;
    m_last = n;
    m_init = 1'b0;
    total++; if (dst !== 3'b110 || lit !== 1'b0) begin bad++; $display("FAIL %s_hit dst=%b lit=%b want 110/0", nm, dst, lit); end
    total++; if (init !== m_init) begin bad++; $display("FAIL %s_init got %b want %b", nm, init, m_init); end
    bcdmux = 1'b0; #1;
    total++; if (bcd !== to_bcd(m_last)) begin bad++; $display("FAIL %s_last got %h want %h", nm, bcd, to_bcd(m_last)); end
    bcdmux = 1'b1; #1;
    total++; if (bcd !== to_bcd(m_best)) begin bad++; $display("FAIL %s_best got %h want %h", nm, bcd, to_bcd(m_best)); end
    bcdmux = 1'b0;
  endtask

  // Press lands on the very edge where the hold-off would expire.
  task automatic test_press_on_expiry();
    int d;
    idle_gap();
    press();
    d = pend_d;
    repeat (d * 1000 - 1) @(negedge clk);
    total++; if (dst !== 3'b001) begin bad++; $display("FAIL expiry_pre got %b want 001", dst); end
    press();
    total++; if (dst !== 3'b011 || miss !== 1'b1 || lit !== 1'b0) begin bad++; $display("FAIL expiry_miss dst=%b miss=%b lit=%b want 011/1/0", dst, miss, lit); end
    bcdmux = 1'b0; #1;
    total++; if (bcd !== to_bcd(m_last)) begin bad++; $display("FAIL expiry_last got %h want %h", bcd, to_bcd(m_last)); end
    bcdmux = 1'b1; #1;
    total++; if (bcd !== to_bcd(m_best)) begin bad++; $display("FAIL expiry_best got %h want %h", bcd, to_bcd(m_best)); end
    bcdmux = 1'b0;
  endtask

  task automatic test_timeout();
    int hold, cnt;
    idle_gap();
    press();
    wait_lit(hold);
    cnt = 0;
    while (!miss && cnt < 1_000_100) begin
      @(negedge clk);
      cnt++;
    end
    total++; if (cnt !== 1_000_000) begin bad++; $display("FAIL timeout_len got %0d want 1000000", cnt); end
    total++; if (dst !== 3'b011 || lit !== 1'b0) begin bad++; $display("FAIL timeout_state dst=%b lit=%b want 011/0", dst, lit); end
    total++; if (init !== m_init) begin bad++; $display("FAIL timeout_init got %b want %b", init, m_init); end
    bcdmux = 1'b0; #1;
    total++; if (bcd !== to_bcd(m_last)) begin bad++; $display("FAIL timeout_last got %h want %h", bcd, to_bcd(m_last)); end
    bcdmux = 1'b1; #1;
    total++; if (bcd !== to_bcd(m_best)) begin bad++; $display("FAIL timeout_best got %h want %h", bcd, to_bcd(m_best)); end
    bcdmux = 1'b0;
  endtask

  task automatic test_async_reset();
    int hold;
    idle_gap();
    press();
    wait_lit(hold);
    repeat ($urandom_range(10, 300)) @(negedge clk);
    total++; if (lit !== 1'b1) begin bad++; $display("FAIL areset_pre lit=%b want 1", lit); end
    #2 rst = 1'b1;
    #1;
    total++; if ({dst, lit, miss, init} !== 6'b000001) begin bad++; $display("FAIL areset_flags got %b want 000001", {dst, lit, miss, init}); end
    total++; if (bcd !== 24'h0) begin bad++; $display("FAIL areset_last got %h want 000000", bcd); end
    bcdmux = 1'b1; #1;
    total++; if (bcd !== 24'h0) begin bad++; $display("FAIL areset_best got %h want 000000", bcd); end
    bcdmux = 1'b0;
    total++; if (dut.lfsr_q !== SEED) begin bad++; $display("FAIL areset_lfsr got %h want %h", dut.lfsr_q, SEED); end
    @(negedge clk);
    rst = 1'b0;
    m_last = 0; m_best = 0; m_init = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_early_press();
    test_round(1234, "r1234");
    test_round(2000, "r2000");
    test_round(500,  "r500");
    for (int i = 0; i < 3; i++) test_round($urandom_range(1, 3000), "rrand");
    test_press_on_expiry();
    test_timeout();
    test_async_reset();
    test_round($urandom_range(600, 3000), "rpost");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
